// File: rtl/fc_score_streamer.sv
// ==== fc_score_streamer : final FC layer, serial features in, NUM_CLASS scores out; optional ROUND_EN ====
// ==== Revision 1.0                                                                                 ====
`default_nettype none

module fc_score_streamer #(
  parameter int INPUT_BITS  = 12,
  parameter int WEIGHT_BITS = 8,
  parameter int BIAS_BITS   = 16,
  parameter int OUTPUT_BITS = 12,
  parameter int ACC_BITS    = 32,
  parameter int FRAC_SHIFT  = 7,
  parameter int NUM_IN      = 48,
  parameter int NUM_CLASS   = 10
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  valid_in,
  input  logic signed [INPUT_BITS-1:0]          data_in,
  input  logic                                  w_we,
  input  logic [$clog2(NUM_IN*NUM_CLASS)-1:0]   w_addr,
  input  logic signed [WEIGHT_BITS-1:0]         w_data,
  input  logic                                  b_we,
  input  logic [$clog2(NUM_CLASS)-1:0]          b_addr,
  input  logic signed [BIAS_BITS-1:0]           b_data,
  output logic signed [OUTPUT_BITS-1:0]         data_out,
  output logic                                  valid_out,
  output logic                                  busy
);

  localparam int NW  = NUM_IN * NUM_CLASS;
  localparam int WAW = $clog2(NW);
  localparam int BAW = $clog2(NUM_CLASS);
  localparam int FCW = $clog2(NUM_IN);
  localparam int CIW = $clog2(NUM_CLASS);
  localparam int PW  = WEIGHT_BITS + INPUT_BITS;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_EMIT = 2'd2} state_t;

  state_t                        state_q, state_d;
  logic [FCW-1:0]                feat_cnt_q, feat_cnt_d;
  logic [CIW-1:0]                cls_idx_q, cls_idx_d;
  logic signed [ACC_BITS-1:0]    acc_q [NUM_CLASS];
  logic signed [ACC_BITS-1:0]    acc_d [NUM_CLASS];
  logic signed [OUTPUT_BITS-1:0] data_out_q, data_out_d;
  logic                          valid_out_q, valid_out_d;

  logic signed [WEIGHT_BITS-1:0] w_mem [NW];
  logic signed [BIAS_BITS-1:0]   b_mem [NUM_CLASS];

  logic signed [PW-1:0]          prod     [NUM_CLASS];
  logic signed [ACC_BITS-1:0]    prod_ext [NUM_CLASS];
  logic signed [BIAS_BITS-1:0]   b_rd;
  logic signed [ACC_BITS-1:0]    sum, sum_r, shifted;
  logic signed [OUTPUT_BITS-1:0] sat;

  // One product per class, all using the weight for the current feature index.
  always_comb begin
    for (int c = 0; c < NUM_CLASS; c++) begin
      prod[c]     = PW'(w_mem[WAW'(c * NUM_IN) + WAW'(feat_cnt_q)]) * PW'(data_in);
      prod_ext[c] = {{(ACC_BITS-PW){prod[c][PW-1]}}, prod[c]};
    end
  end

  always_comb begin
    b_rd = b_mem[cls_idx_q];
    sum  = acc_q[cls_idx_q] + {{(ACC_BITS-BIAS_BITS){b_rd[BIAS_BITS-1]}}, b_rd};
`ifdef ROUND_EN
    sum_r = sum + (ACC_BITS'(1) <<< (FRAC_SHIFT - 1));
`else
    sum_r = sum;
`endif
    shifted = sum_r >>> FRAC_SHIFT;
    // In range when every bit above the output sign bit matches it.
    if ((&shifted[ACC_BITS-1:OUTPUT_BITS-1]) || !(|shifted[ACC_BITS-1:OUTPUT_BITS-1])) begin
      sat = shifted[OUTPUT_BITS-1:0];
    end else if (shifted[ACC_BITS-1]) begin
      sat = {1'b1, {(OUTPUT_BITS-1){1'b0}}};
    end else begin
      sat = {1'b0, {(OUTPUT_BITS-1){1'b1}}};
    end
  end

  always_comb begin
    state_d     = state_q;
    feat_cnt_d  = feat_cnt_q;
    cls_idx_d   = cls_idx_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    valid_out_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_in) begin
          for (int c = 0; c < NUM_CLASS; c++) acc_d[c] = prod_ext[c];
          feat_cnt_d = FCW'(1);
          state_d    = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (valid_in) begin
          for (int c = 0; c < NUM_CLASS; c++) acc_d[c] = acc_q[c] + prod_ext[c];
          if (feat_cnt_q == FCW'(NUM_IN - 1)) begin
            feat_cnt_d = '0;
            cls_idx_d  = '0;
            state_d    = S_EMIT;
          end else begin
            feat_cnt_d = feat_cnt_q + FCW'(1);
          end
        end
      end
      S_EMIT: begin
        valid_out_d = 1'b1;
        data_out_d  = sat;
        if (cls_idx_q == CIW'(NUM_CLASS - 1)) begin
          cls_idx_d = '0;
          for (int c = 0; c < NUM_CLASS; c++) acc_d[c] = '0;
          state_d = S_IDLE;
        end else begin
          cls_idx_d = cls_idx_q + CIW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      feat_cnt_q  <= '0;
      cls_idx_q   <= '0;
      for (int c = 0; c < NUM_CLASS; c++) acc_q[c] <= '0;
      data_out_q  <= '0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      feat_cnt_q  <= feat_cnt_d;
      cls_idx_q   <= cls_idx_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
    end
  end

  // Parameter store survives reset; only writable between frames.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE) begin
      if (w_we && (w_addr < WAW'(NW)))       w_mem[w_addr] <= w_data;
      if (b_we && (b_addr < BAW'(NUM_CLASS))) b_mem[b_addr] <= b_data;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fc_score_streamer.sv
// ==== tb_fc_score_streamer : table-driven frames plus reset / write-gating sequences ====
// ==== Revision 1.0                                                                    ====
`default_nettype none

module tb_fc_score_streamer;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_in;
  logic signed [11:0] data_in;
  logic              w_we;
  logic [8:0]        w_addr;
  logic signed [7:0] w_data;
  logic              b_we;
  logic [3:0]        b_addr;
  logic signed [15:0] b_data;
  logic signed [11:0] data_out;
  logic              valid_out;
  logic              busy;

  int total = 0;
  int bad   = 0;

  fc_score_streamer dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .b_we(b_we), .b_addr(b_addr), .b_data(b_data),
    .data_out(data_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  // wmode: 0 all zero, 1 only class 3 = 1, 2 all 127, 3 all -128
  typedef struct packed {
    logic [1:0]         wmode;
    logic signed [11:0] feat;
    logic               gap;
    logic signed [15:0] b0;
    logic signed [15:0] b1;
    logic signed [15:0] b2;
    logic [119:0]       exp;
  } vec_t;

  vec_t vecs [5];
  logic [119:0] hot_exp;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic load_weights(input logic [1:0] mode);
    w_we = 1'b1;
    for (int a = 0; a < 480; a++) begin
      w_addr = 9'(a);
      case (mode)
        2'd0: w_data = 8'sd0;
        2'd1: w_data = ((a / 48) == 3) ? 8'sd1 : 8'sd0;
        2'd2: w_data = 8'sd127;
        default: w_data = -8'sd128;
      endcase
      step();
    end
    w_we = 1'b0;
  endtask

  task automatic load_bias(input logic signed [15:0] b0, input logic signed [15:0] b1,
                           input logic signed [15:0] b2);
    b_we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      b_addr = 4'(i);
      b_data = (i == 0) ? b0 : (i == 1) ? b1 : (i == 2) ? b2 : 16'sd0;
      step();
    end
    b_we = 1'b0;
  endtask

  task automatic run_frame(input string tag, input logic signed [11:0] feat, input logic gap,
                           input logic junk, input logic wr_in_emit, input logic [119:0] exp);
    int early_vo = 0;
    for (int k = 0; k < 48; k++) begin
      valid_in = 1'b1;
      data_in  = feat;
      step();
      if (valid_out) early_vo++;
      valid_in = 1'b0;
      if (gap && k < 47) begin
        step();
        if (valid_out) early_vo++;
      end
    end
    check({tag, " early_valid_out"}, early_vo, 0);
    check({tag, " busy_at_last_beat"}, int'(busy), 1);
    check({tag, " no_valid_yet"}, int'(valid_out), 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 9) begin
        valid_in = 1'b0;
        w_we     = 1'b0;
      end else begin
        if (junk) begin
          valid_in = 1'b1;
          data_in  = 12'sd1000;
        end
        if (wr_in_emit) begin
          w_we   = 1'b1;
          w_addr = 9'd144;
          w_data = 8'sd0;
        end
      end
      step();
      check($sformatf("%s valid_out[%0d]", tag, c), int'(valid_out), 1);
      check($sformatf("%s score[%0d]", tag, c), int'(data_out), int'($signed(exp[c*12 +: 12])));
      check($sformatf("%s busy[%0d]", tag, c), int'(busy), (c < 9) ? 1 : 0);
    end
    step();
    check({tag, " valid_out_drop"}, int'(valid_out), 0);
    check({tag, " data_out_hold"}, int'(data_out), int'($signed(exp[9*12 +: 12])));
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; data_in = '0;
    w_we = 1'b0; w_addr = '0; w_data = '0;
    b_we = 1'b0; b_addr = '0; b_data = '0;

    hot_exp = '0;
    hot_exp[3*12 +: 12] = 12'd48;

    vecs[0] = '{wmode: 2'd1, feat: 12'sd128,  gap: 1'b0, b0: 16'sd0,   b1: 16'sd0,  b2: 16'sd0,  exp: hot_exp};
    vecs[1] = '{wmode: 2'd2, feat: 12'sd2047, gap: 1'b0, b0: 16'sd0,   b1: 16'sd0,  b2: 16'sd0,  exp: {10{12'h7FF}}};
    vecs[2] = '{wmode: 2'd3, feat: 12'sd2047, gap: 1'b0, b0: 16'sd0,   b1: 16'sd0,  b2: 16'sd0,  exp: {10{12'h800}}};
`ifdef ROUND_EN
    vecs[3] = '{wmode: 2'd0, feat: 12'sd100,  gap: 1'b0, b0: 16'sd256, b1: 16'sd64, b2: -16'sd1,
                exp: {84'd0, 12'sd0, 12'sd1, 12'sd2}};
`else
    vecs[3] = '{wmode: 2'd0, feat: 12'sd100,  gap: 1'b0, b0: 16'sd256, b1: 16'sd64, b2: -16'sd1,
                exp: {84'd0, -12'sd1, 12'sd0, 12'sd2}};
`endif
    vecs[4] = '{wmode: 2'd1, feat: 12'sd128,  gap: 1'b1, b0: 16'sd0,   b1: 16'sd0,  b2: 16'sd0,  exp: hot_exp};

    repeat (3) step();
    check("reset data_out", int'(data_out), 0);
    check("reset valid_out", int'(valid_out), 0);
    check("reset busy", int'(busy), 0);
    rst = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      load_weights(vecs[i].wmode);
      load_bias(vecs[i].b0, vecs[i].b1, vecs[i].b2);
      run_frame($sformatf("vec%0d", i), vecs[i].feat, vecs[i].gap, vecs[i].gap, 1'b0, vecs[i].exp);
    end

    // Abort a frame after 20 beats; the following frame must start from feature 0.
    for (int k = 0; k < 20; k++) begin
      valid_in = 1'b1;
      data_in  = 12'sd128;
      step();
    end
    valid_in = 1'b0;
    check("midframe busy", int'(busy), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("after_rst busy", int'(busy), 0);
    check("after_rst valid_out", int'(valid_out), 0);
    run_frame("post_rst", 12'sd128, 1'b0, 1'b0, 1'b0, hot_exp);

    // Weight write attempted during EMIT must be ignored.
    run_frame("wr_emit", 12'sd128, 1'b0, 1'b0, 1'b1, hot_exp);
    run_frame("wr_after", 12'sd128, 1'b0, 1'b0, 1'b0, hot_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fc_score_streamer.md
Name: fc_score_streamer

Overview:
- Final fully-connected layer of the CNN; the producer end of the classifier's score stream.
- Accepts a flattened feature vector serially, one feature per valid beat.
- Accumulates NUM_CLASS dot products in parallel against a runtime-loadable weight/bias store.
- Emits NUM_CLASS signed scores in class order, one per cycle, on a contiguous valid_out burst sized for the classifier's input.

Parameters:
INPUT_BITS, 12, feature width (signed)
WEIGHT_BITS, 8, weight width (signed)
BIAS_BITS, 16, bias width (signed)
OUTPUT_BITS, 12, score width (signed); matches classifier INPUT_BITS
ACC_BITS, 32, accumulator width (signed)
FRAC_SHIFT, 7, arithmetic right shift applied to acc+bias before saturation
NUM_IN, 48, features per frame
NUM_CLASS, 10, output neurons / scores per frame

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; synchronous, active-high
valid_in  in  1  feature beat valid
data_in  in  INPUT_BITS  signed feature
w_we  in  1  weight write enable
w_addr  in  $clog2(NUM_IN*NUM_CLASS)  weight address = class*NUM_IN + feature_index
w_data  in  WEIGHT_BITS  signed weight
b_we  in  1  bias write enable
b_addr  in  $clog2(NUM_CLASS)  bias index
b_data  in  BIAS_BITS  signed bias
data_out  out  OUTPUT_BITS  signed score, class order
valid_out  out  1  score valid
busy  out  1  high in ACCUM-after-first-beat or EMIT

Behaviour:
- Clock and reset: one clock clk. rst is synchronous, active-high.
- Reset effects: state goes to IDLE; feature counter, class counter and all accumulators go to 0; data_out=0, valid_out=0, busy=0.
- Reset does not clear the weight/bias store.
- States:
  - IDLE: valid_in=1 takes the beat as feature 0 (acc[c] <= W[c][0]*data_in); go to ACCUM with count=1.
  - ACCUM: each valid_in=1 beat k adds W[c][k]*data_in to acc[c] for all c in parallel. Gaps (valid_in=0) are allowed; state holds.
  - ACCUM to EMIT: on the edge that accepts beat NUM_IN-1, go to EMIT with idx=0.
  - EMIT: each cycle registers data_out=sat(((acc[idx]+sext(bias[idx])) >>> FRAC_SHIFT)) and valid_out=1, then idx++.
  - EMIT to IDLE: on idx==NUM_CLASS-1, go to IDLE and clear the accumulators. valid_out drops on the next edge unless a new frame emits.
- Latency: the last feature is accepted at edge N. Scores for class 0..NUM_CLASS-1 are valid after edges N+1..N+NUM_CLASS.
- valid_out is high for exactly NUM_CLASS consecutive cycles per frame, never more and never split.
- Arithmetic:
  - Products are full-width signed, sign-extended to ACC_BITS.
  - Accumulation wraps modulo 2^ACC_BITS; the defaults cannot overflow.
  - Shift is arithmetic (floor toward −inf).
  - Saturation clamps to [−2^(OUTPUT_BITS−1), 2^(OUTPUT_BITS−1)−1].
- valid_in during EMIT is ignored; those beats are dropped and busy=1 signals this. The upstream must hold data while busy.
- Weight/bias writes:
  - Take effect on the edge when state is IDLE; writes in ACCUM or EMIT are ignored.
  - Out-of-range addresses are ignored.
  - Simultaneous w_we and b_we are both honoured.
  - A write at the same edge as the IDLE valid_in beat 0 is committed, but beat 0 uses the old weight.
- Reset mid-frame (ACCUM or EMIT): the frame is aborted with no further valid_out. The next frame starts from feature 0.
- data_out holds its last value when valid_out=0.

Optional Feature:
ROUND_EN:
- Defined: add 2^(FRAC_SHIFT−1) to acc+bias before the shift (round half up), then saturate.
- Undefined: plain truncating arithmetic shift.
- Port list and timing are identical in both builds.

Test Plan:
- Single hot class: all W=0 except W[3][k]=1 for all k, bias=0, 48 features of 128 -> data_out sequence 0,0,0,48,0,0,0,0,0,0. valid_out high 10 consecutive cycles starting 1 cycle after the last beat.
- Saturation: all W=127, features 2047 -> all 10 scores 2047. All W=−128, features 2047 -> all −2048.
- Bias and rounding: W=0, bias[0]=256, bias[1]=64, bias[2]=−1:
  - Without ROUND_EN -> scores 2,0,−1.
  - With ROUND_EN -> scores 2,1,0.
- Gapped input and busy drop: frame with valid_in toggling 1/0 yields the same scores as a gapless frame. Beats driven during EMIT are dropped, with busy=1 throughout EMIT.
- Reset mid-ACCUM: rst after 20 beats, then a full 48-beat hot-class frame -> output identical to the single-hot-class case; no valid_out before that frame completes.
- Write gating: w_we to W[3][0]=0 issued during EMIT is ignored. The next frame is unchanged (score 48).
